// File: rtl/serial_pattern_source.sv
// Serial pattern source: latches a parallel pattern on a start edge and shifts it out MSB-first,
// one bit per TICK_DIV clocks, with a per-bit strobe. Optional macro PATTERN_LOOP_EN enables streaming repeat.
module serial_pattern_source #(
    parameter int PAT_WIDTH = 8,
    parameter int TICK_DIV  = 25000000
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic [PAT_WIDTH-1:0] pattern_in,
    input  logic                 start,
    output logic                 w_out,
    output logic                 bit_valid,
    output logic                 busy,
    output logic                 done
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BITS_W = $clog2(PAT_WIDTH + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [BITS_W-1:0] BITS_FULL = BITS_W'(PAT_WIDTH);
    localparam logic [BITS_W-1:0] BITS_ONE  = BITS_W'(1);

    if (PAT_WIDTH < 1 || TICK_DIV < 1) begin : g_param_check
        $error("serial_pattern_source: PAT_WIDTH and TICK_DIV must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state;
    logic [PAT_WIDTH-1:0]  shreg;
    logic [TICK_W-1:0]     tick_cnt;
    logic [BITS_W-1:0]     bits_left;
    logic                  start_q;
    logic                  tick_last;
    logic                  start_rise;
`ifdef PATTERN_LOOP_EN
    logic [PAT_WIDTH-1:0]  pattern_reg;
`endif

    assign tick_last  = (tick_cnt == TICK_LAST);
    assign start_rise = start && !start_q;
    assign w_out      = (state == SHIFT) && shreg[PAT_WIDTH-1];
    assign bit_valid  = (state == SHIFT) && tick_last;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state     <= IDLE;
            shreg     <= '0;
            tick_cnt  <= '0;
            bits_left <= '0;
            start_q   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef PATTERN_LOOP_EN
            pattern_reg <= '0;
`endif
        end else begin
            // start_q tracks start in every state so a held level never retriggers
            start_q <= start;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start_rise) begin
                        shreg     <= pattern_in;
`ifdef PATTERN_LOOP_EN
                        pattern_reg <= pattern_in;
`endif
                        tick_cnt  <= '0;
                        bits_left <= BITS_FULL;
                        state     <= SHIFT;
                        busy      <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (tick_last) begin
                        tick_cnt  <= '0;
                        shreg     <= shreg << 1;
                        bits_left <= bits_left - BITS_ONE;
                        if (bits_left == BITS_ONE) begin
`ifdef PATTERN_LOOP_EN
                            // Held start at the last bit restarts from the latched copy, not pattern_in
                            if (start) begin
                                shreg     <= pattern_reg;
                                bits_left <= BITS_FULL;
                            end else begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
`else
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
`endif
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_pattern_source.sv
// Directed bench for serial_pattern_source: one DUT at TICK_DIV=4, one at TICK_DIV=1.
module tb_serial_pattern_source;

    logic       clock;
    logic       resetn;
    logic [7:0] pattern_in;
    logic       start;
    logic       w_out, bit_valid, busy, done;

    logic [7:0] f_pattern;
    logic       f_start;
    logic       f_w, f_valid, f_busy, f_done;

    int n_tests;
    int n_fail;

    int cyc;
    int n_str;
    int n_done;
    int done_cyc;
    int busy_hi;
    int str_cyc [64];
    logic str_bit [64];

    serial_pattern_source #(.PAT_WIDTH(8), .TICK_DIV(4)) u_dut (
        .clock(clock), .resetn(resetn), .pattern_in(pattern_in), .start(start),
        .w_out(w_out), .bit_valid(bit_valid), .busy(busy), .done(done)
    );

    serial_pattern_source #(.PAT_WIDTH(8), .TICK_DIV(1)) u_fast (
        .clock(clock), .resetn(resetn), .pattern_in(f_pattern), .start(f_start),
        .w_out(f_w), .bit_valid(f_valid), .busy(f_busy), .done(f_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cap_clear();
        cyc = 0; n_str = 0; n_done = 0; done_cyc = -1; busy_hi = 0;
    endtask

    // Advance ncyc edges, logging strobes/done/busy of the TICK_DIV=4 instance
    task automatic capture(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clock); #1;
            if (bit_valid) begin
                if (n_str < 64) begin
                    str_cyc[n_str] = cyc;
                    str_bit[n_str] = w_out;
                end
                n_str++;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (busy) busy_hi++;
            cyc++;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; pattern_in = 8'h00;
        f_start = 1'b0; f_pattern = 8'h00;
        idle_cycles(2);
        n_tests++; if (w_out !== 1'b0) begin n_fail++; $display("FAIL reset_w_out got %b exp 0", w_out); end
        n_tests++; if (bit_valid !== 1'b0) begin n_fail++; $display("FAIL reset_bit_valid got %b exp 0", bit_valid); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
        n_tests++; if (f_busy !== 1'b0 || f_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fast got busy=%b valid=%b exp 0 0", f_busy, f_valid); end
        resetn = 1'b1;
        cap_clear();
        capture(6);
        n_tests++; if (busy_hi !== 0 || n_str !== 0) begin n_fail++; $display("FAIL idle_no_start got busy_cycles=%0d strobes=%0d exp 0 0", busy_hi, n_str); end
    endtask

    task automatic test_basic();
        logic [7:0] pat;
        pat = 8'b11010110;
        cap_clear();
        pattern_in = pat; start = 1'b1;
        capture(40);
        start = 1'b0;
        n_tests++; if (n_str !== 8) begin n_fail++; $display("FAIL basic_strobe_count got %0d exp 8", n_str); end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (str_cyc[i] !== 4*i+3 || str_bit[i] !== pat[7-i]) begin
                n_fail++;
                $display("FAIL basic_bit%0d got cyc=%0d w=%b exp cyc=%0d w=%b", i, str_cyc[i], str_bit[i], 4*i+3, pat[7-i]);
            end
        end
        n_tests++; if (busy_hi !== 32) begin n_fail++; $display("FAIL basic_busy_cycles got %0d exp 32", busy_hi); end
        n_tests++; if (n_done !== 1 || done_cyc !== 32) begin n_fail++; $display("FAIL basic_done got count=%0d cyc=%0d exp 1 32", n_done, done_cyc); end
    endtask

`ifndef PATTERN_LOOP_EN
    task automatic test_held_start();
        logic [7:0] pat;
        pat = 8'h3C;
        idle_cycles(1);
        cap_clear();
        pattern_in = pat; start = 1'b1;
        capture(100);
        n_tests++; if (n_str !== 8 || n_done !== 1) begin n_fail++; $display("FAIL held_single_tx got strobes=%0d done=%0d exp 8 1", n_str, n_done); end
        start = 1'b0;
        idle_cycles(1);
        cap_clear();
        start = 1'b1;
        capture(40);
        start = 1'b0;
        n_tests++; if (n_str !== 8 || n_done !== 1 || done_cyc !== 32) begin n_fail++; $display("FAIL held_second_tx got strobes=%0d done=%0d done_cyc=%0d exp 8 1 32", n_str, n_done, done_cyc); end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (str_bit[i] !== pat[7-i]) begin n_fail++; $display("FAIL held_second_bit%0d got %b exp %b", i, str_bit[i], pat[7-i]); end
        end
    endtask
`endif

    task automatic test_reset_mid();
        idle_cycles(1);
        cap_clear();
        pattern_in = 8'b11010110; start = 1'b1;
        capture(12);
        n_tests++; if (n_str !== 3) begin n_fail++; $display("FAIL midreset_pre_strobes got %0d exp 3", n_str); end
        resetn = 1'b0; start = 1'b0;
        idle_cycles(1);
        n_tests++;
        if ({w_out, bit_valid, busy, done} !== 4'b0000) begin
            n_fail++; $display("FAIL midreset_outputs got %b exp 0000", {w_out, bit_valid, busy, done});
        end
        resetn = 1'b1;
        cap_clear();
        capture(40);
        n_tests++; if (n_str !== 0 || n_done !== 0 || busy_hi !== 0) begin n_fail++; $display("FAIL midreset_quiet got strobes=%0d done=%0d busy=%0d exp 0 0 0", n_str, n_done, busy_hi); end
    endtask

    task automatic test_ignore_during_shift();
        logic [7:0] pat;
        pat = 8'b11010110;
        cap_clear();
        pattern_in = pat; start = 1'b1;
        capture(10);
        pattern_in = 8'h00; start = 1'b0;
        capture(2);
        start = 1'b1;
        capture(30);
        start = 1'b0;
        n_tests++; if (n_str !== 8 || n_done !== 1 || done_cyc !== 32) begin n_fail++; $display("FAIL shiftign_count got strobes=%0d done=%0d done_cyc=%0d exp 8 1 32", n_str, n_done, done_cyc); end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (str_bit[i] !== pat[7-i] || str_cyc[i] !== 4*i+3) begin
                n_fail++; $display("FAIL shiftign_bit%0d got cyc=%0d w=%b exp cyc=%0d w=%b", i, str_cyc[i], str_bit[i], 4*i+3, pat[7-i]);
            end
        end
        idle_cycles(2);
    endtask

    task automatic test_tick1();
        logic [7:0] pat;
        int fs_n, fd_cyc;
        int fs_cyc [16];
        logic fs_bit [16];
        pat = 8'hA5;
        fs_n = 0; fd_cyc = -1;
        f_pattern = pat; f_start = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(posedge clock); #1;
            if (f_valid) begin
                if (fs_n < 16) begin fs_cyc[fs_n] = c; fs_bit[fs_n] = f_w; end
                fs_n++;
            end
            if (f_done) fd_cyc = c;
        end
        f_start = 1'b0;
        n_tests++; if (fs_n !== 8) begin n_fail++; $display("FAIL tick1_count got %0d exp 8", fs_n); end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (fs_cyc[i] !== i || fs_bit[i] !== pat[7-i]) begin
                n_fail++; $display("FAIL tick1_bit%0d got cyc=%0d w=%b exp cyc=%0d w=%b", i, fs_cyc[i], fs_bit[i], i, pat[7-i]);
            end
        end
        n_tests++; if (fd_cyc !== 8) begin n_fail++; $display("FAIL tick1_done got cyc=%0d exp 8", fd_cyc); end
    endtask

`ifdef PATTERN_LOOP_EN
    task automatic test_loop();
        logic [7:0] pat;
        pat = 8'b11010110;
        idle_cycles(1);
        cap_clear();
        pattern_in = pat; start = 1'b1;
        capture(2);
        pattern_in = 8'h00;
        capture(68);
        n_tests++; if (n_str !== 17 || n_done !== 0) begin n_fail++; $display("FAIL loop_stream got strobes=%0d done=%0d exp 17 0", n_str, n_done); end
        start = 1'b0;
        capture(40);
        n_tests++; if (n_str !== 24 || n_done !== 1 || done_cyc !== 96) begin n_fail++; $display("FAIL loop_stop got strobes=%0d done=%0d done_cyc=%0d exp 24 1 96", n_str, n_done, done_cyc); end
        for (int i = 0; i < 24; i++) begin
            n_tests++;
            if (str_cyc[i] !== 4*i+3 || str_bit[i] !== pat[7-(i%8)]) begin
                n_fail++; $display("FAIL loop_bit%0d got cyc=%0d w=%b exp cyc=%0d w=%b", i, str_cyc[i], str_bit[i], 4*i+3, pat[7-(i%8)]);
            end
        end
    endtask
`endif

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_basic();
`ifndef PATTERN_LOOP_EN
        test_held_start();
`endif
        test_reset_mid();
        test_ignore_during_shift();
        test_tick1();
`ifdef PATTERN_LOOP_EN
        test_loop();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_pattern_source.md
Name: serial_pattern_source

Overview:
- Upstream stimulus stage for the serial sequence-detector FSM.
- Latches a parallel bit pattern from switches, then shifts it out MSB-first on a single serial line at a divided rate.
- Emits a one-cycle strobe per bit so the detector can advance exactly once per presented bit, replacing manual push-button clocking.
- w_out feeds the detector's w input; bit_valid feeds the detector's clock-enable.

Parameters:
- PAT_WIDTH, 8, number of pattern bits shifted out per transmission (at least 1).
- TICK_DIV, 25000000, clock cycles per serial bit (at least 1; 1 s per bit at 25 MHz; set to 4 in simulation).

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- resetn  input  1  synchronous, active-low reset.
- pattern_in  input  PAT_WIDTH  parallel pattern; sampled only on an accepted start.
- start  input  1  level input; its rising edge (start=1 now, 0 on the previous sampled edge) requests a transmission.
- w_out  output  1  current serial bit.
- bit_valid  output  1  one-cycle strobe; w_out is valid and stable during this cycle.
- busy  output  1  high while in the SHIFT state.
- done  output  1  one-cycle pulse after the final bit of a transmission.

Behaviour:
- Reset: on a rising clock edge with resetn=0:
  - state=IDLE; shift register, tick counter, bits_left and start_q all cleared.
  - w_out=0, bit_valid=0, busy=0, done=0.
  - Reset overrides all other activity, including mid-transmission; no strobes are issued after a reset edge.
- start_q registers start on every non-reset edge, including while busy. A held start therefore never retriggers.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - w_out=0, busy=0.
  - On an edge where the start rising edge is detected: shreg<=pattern_in, tick_cnt<=0, bits_left<=PAT_WIDTH, state<=SHIFT.
- SHIFT:
  - busy=1; w_out=shreg[PAT_WIDTH-1] combinationally.
  - tick_cnt increments each cycle.
  - bit_valid=1 (combinational) exactly in cycles where tick_cnt==TICK_DIV-1.
  - On that cycle's closing edge: tick_cnt<=0, shreg shifts left by 1 with 0 fill, bits_left decrements.
  - If bits_left==1 at that edge, state<=DONE.
- DONE:
  - Lasts exactly one cycle; done=1, busy=0, w_out=0; then state<=IDLE.
  - A start edge arriving during DONE is ignored. The start_q update still occurs.
- Timing with TICK_DIV=T: if the start edge is detected at edge 0, bit i (i=0..PAT_WIDTH-1) has bit_valid high in the cycle between edges (i+1)*T-1 and (i+1)*T.
- T=1: bit_valid is high on every SHIFT cycle.
- start edges during SHIFT are ignored.
- pattern_in changes during SHIFT have no effect.
- Widths:
  - tick_cnt is wide enough to hold TICK_DIV-1 (clog2, minimum 1).
  - bits_left is clog2(PAT_WIDTH+1) bits.
  - All counters are unsigned and never wrap in legal operation.
- Illegal parameter values (0) are unsupported. Enforce them with a generate-time check.

Optional Feature:
- Macro: PATTERN_LOOP_EN.
- Defined: at the edge closing the final bit's strobe, if start==1 (level) at that edge:
  - shreg reloads from the previously latched pattern copy (pattern_reg, captured at the initial accept), not from pattern_in.
  - bits_left<=PAT_WIDTH; tick_cnt<=0; state stays SHIFT.
  - No done pulse occurs; streaming continues seamlessly.
  - If start==0 at that edge, behaviour is the normal transition to DONE.
- Not defined: pattern_reg is not instantiated, and every transmission ends in DONE regardless of start.

Test Plan (PAT_WIDTH=8, TICK_DIV=4):
- Hold resetn=0 for 2 edges -> w_out, bit_valid, busy and done all 0; busy stays 0 with start=0.
- pattern_in=8'b11010110, start 0->1 at edge 0 -> exactly 8 bit_valid strobes at cycles 3,7,...,31 with w_out=1,1,0,1,0,1,1,0; busy=1 through cycle 31; done=1 in cycle 32 only.
- start held high for 100 cycles -> exactly one transmission (8 strobes, 1 done); a second 0->1 start after done -> a second transmission.
- Drive resetn=0 on the edge after the 3rd strobe -> all outputs 0 on that edge; no further strobes or done until a new start.
- Change pattern_in to 8'h00 and pulse start again during SHIFT -> serial output unchanged; no restart; strobe count stays 8.
- TICK_DIV=1, pattern_in=8'hA5 -> strobes on 8 consecutive cycles; w_out=1,0,1,0,0,1,0,1.
- PATTERN_LOOP_EN defined, start held high -> 16+ consecutive strobes repeating 11010110 with no done pulse; drop start before a final bit -> done follows that pattern's last strobe.
